// File: rtl/stream_merge_2to1.sv
// rtl/stream_merge_2to1.sv - 2-to-1 valid/ready stream merge, packet-level round-robin
module stream_merge_2to1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              rr, rr_nxt;
  logic              load;
  logic              gnt_vld, gnt_ch;
  logic              acc, acc_last;
  logic [DATA_W-1:0] acc_data;

  assign load = ~out_valid | out_ready;

  // A locked channel keeps the grant even while its valid is low mid-packet.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = 1'b0;
    case (state)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          gnt_vld = 1'b1;
          gnt_ch  = rr;
        end else if (in0_valid) begin
          gnt_vld = 1'b1;
        end else if (in1_valid) begin
          gnt_vld = 1'b1;
          gnt_ch  = 1'b1;
        end
      end
      LOCK0: gnt_vld = 1'b1;
      LOCK1: begin
        gnt_vld = 1'b1;
        gnt_ch  = 1'b1;
      end
      default: ;
    endcase
  end

  // rst_n gating keeps both readys low while reset is held.
  assign in0_ready = rst_n & load & gnt_vld & ~gnt_ch;
  assign in1_ready = rst_n & load & gnt_vld & gnt_ch;

  assign acc      = gnt_ch ? (in1_valid & in1_ready) : (in0_valid & in0_ready);
  assign acc_data = gnt_ch ? in1_data : in0_data;
  assign acc_last = gnt_ch ? in1_last : in0_last;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    if (acc) begin
      if (acc_last) begin
        state_nxt = IDLE;
        rr_nxt    = ~gnt_ch;
      end else begin
        state_nxt = gnt_ch ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= acc_data;
        out_last  <= acc_last;
        out_src   <= gnt_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
